// File: rtl/mfp_sevenseg_mux.sv
// Eight-digit multiplexed seven-segment driver with a frame-synchronous shadow/active data copy.
// Optional anti-ghosting guard blanking: define MFP_SEVSEG_GUARD_EN.
module mfp_sevenseg_mux #(
    parameter int unsigned REFRESH_CYCLES = 50000,
    parameter int unsigned GUARD_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] digits,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_in,
    output logic        CA,
    output logic        CB,
    output logic        CC,
    output logic        CD,
    output logic        CE,
    output logic        CF,
    output logic        CG,
    output logic        DP,
    output logic [7:0]  AN,
    output logic        frame_tick
);

    localparam int unsigned CNT_W = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    if (REFRESH_CYCLES < 4 || GUARD_CYCLES >= REFRESH_CYCLES) begin : g_bad_params
        $error("mfp_sevenseg_mux: REFRESH_CYCLES must be >= 4 and exceed GUARD_CYCLES");
    end

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic             slot_end;
    logic             frame_end;

    logic [31:0] shadow_digits, act_digits;
    logic [7:0]  shadow_en, act_en;
    logic [7:0]  shadow_dp, act_dp;

    logic [6:0]  seg_q, seg_d;
    logic [7:0]  an_d;
    logic        dp_d;
    logic        tick_d;
    logic [3:0]  nib;
    logic        lit;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 3'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A load coinciding with the frame wrap bypasses the shadow so it is shown immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_digits <= '0;
            shadow_en     <= '0;
            shadow_dp     <= '0;
            act_digits    <= '0;
            act_en        <= '0;
            act_dp        <= '0;
        end else begin
            if (load) begin
                shadow_digits <= digits;
                shadow_en     <= digit_en;
                shadow_dp     <= dp_in;
            end
            if (frame_end) begin
                act_digits <= load ? digits   : shadow_digits;
                act_en     <= load ? digit_en : shadow_en;
                act_dp     <= load ? dp_in    : shadow_dp;
            end
        end
    end

    function automatic logic [6:0] seg_lut(input logic [3:0] v);
        case (v)
            4'h0: seg_lut = 7'h40;
            4'h1: seg_lut = 7'h79;
            4'h2: seg_lut = 7'h24;
            4'h3: seg_lut = 7'h30;
            4'h4: seg_lut = 7'h19;
            4'h5: seg_lut = 7'h12;
            4'h6: seg_lut = 7'h02;
            4'h7: seg_lut = 7'h78;
            4'h8: seg_lut = 7'h00;
            4'h9: seg_lut = 7'h10;
            4'hA: seg_lut = 7'h08;
            4'hB: seg_lut = 7'h03;
            4'hC: seg_lut = 7'h46;
            4'hD: seg_lut = 7'h21;
            4'hE: seg_lut = 7'h06;
            default: seg_lut = 7'h0E;
        endcase
    endfunction

    always_comb begin
        nib = act_digits[{idx, 2'b00} +: 4];
`ifdef MFP_SEVSEG_GUARD_EN
        lit = act_en[idx] && !(32'(cnt) < GUARD_CYCLES);
`else
        lit = act_en[idx];
`endif
        an_d   = 8'hFF;
        seg_d  = 7'h7F;
        dp_d   = 1'b1;
        tick_d = (idx == 3'd0) && (cnt == '0);
        if (lit) begin
            an_d  = ~(8'h01 << idx);
            seg_d = seg_lut(nib);
            dp_d  = ~act_dp[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            AN         <= 8'hFF;
            seg_q      <= 7'h7F;
            DP         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            AN         <= an_d;
            seg_q      <= seg_d;
            DP         <= dp_d;
            frame_tick <= tick_d;
        end
    end

    assign {CG, CF, CE, CD, CC, CB, CA} = seg_q;

endmodule

// File: tb/tb_mfp_sevenseg_mux.sv
// Self-checking bench for mfp_sevenseg_mux: directed table, corner-case sequences and randomized traffic.
module tb_mfp_sevenseg_mux;

    localparam int unsigned RC    = 4;
    localparam int unsigned GC    = 1;
    localparam int unsigned FRAME = 8 * RC;
`ifdef MFP_SEVSEG_GUARD_EN
    localparam int unsigned GPH = GC;
`else
    localparam int unsigned GPH = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [31:0] digits = '0;
    logic [7:0]  digit_en = '0;
    logic [7:0]  dp_in = '0;
    logic        CA, CB, CC, CD, CE, CF, CG, DP, frame_tick;
    logic [7:0]  AN;

    mfp_sevenseg_mux #(.REFRESH_CYCLES(RC), .GUARD_CYCLES(GC)) dut (
        .clk(clk), .reset(reset), .load(load), .digits(digits), .digit_en(digit_en),
        .dp_in(dp_in), .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG),
        .DP(DP), .AN(AN), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference: k counts edges since reset release; outputs after edge k show frame position k mod FRAME.
    logic [31:0] sh_d, ac_d;
    logic [7:0]  sh_e, ac_e, sh_p, ac_p;
    int unsigned k;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_tick;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic rst, input logic ld, input logic [31:0] d,
                         input logic [7:0] en, input logic [7:0] dp);
        int unsigned p, dig, ph;
        logic lit;
        logic [3:0] nib;
        @(negedge clk);
        reset = rst; load = ld; digits = d; digit_en = en; dp_in = dp;
        @(posedge clk);
        if (rst) begin
            k = 0;
            sh_d = '0; sh_e = '0; sh_p = '0;
            ac_d = '0; ac_e = '0; ac_p = '0;
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
        end else begin
            p   = k % FRAME;
            dig = p / RC;
            ph  = p % RC;
            nib = ac_d[dig*4 +: 4];
            lit = ac_e[dig] && (ph >= GPH);
            e_an   = lit ? ~(8'h01 << dig) : 8'hFF;
            e_seg  = lit ? seg_tab[nib] : 7'h7F;
            e_dp   = lit ? ~ac_p[dig] : 1'b1;
            e_tick = (p == 0);
            if (ld) begin
                sh_d = d; sh_e = en; sh_p = dp;
            end
            if (p == FRAME - 1) begin
                ac_d = sh_d; ac_e = sh_e; ac_p = sh_p;
            end
            k++;
        end
        #1;
        chk("scan", {15'd0, AN, CG, CF, CE, CD, CC, CB, CA, DP, frame_tick},
                    {15'd0, e_an, e_seg, e_dp, e_tick});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, digits, digit_en, dp_in);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, digits, digit_en, dp_in);
    endtask

    // Advance until the next edge lands on frame position tp.
    task automatic run_to(input int unsigned tp);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (k % FRAME == tp) return;
            idle(1);
        end
        chk("run_to_bound", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [31:0] d;
        logic [7:0]  en;
        logic [7:0]  dp;
        int unsigned slot;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dpo;
    } vec_t;

    vec_t vecs [7];
    int   ticks;

    initial begin
        vecs[0] = '{32'h89AB_CDEF, 8'hFF, 8'h01, 0, 8'hFE, 7'h0E, 1'b0};
        vecs[1] = '{32'h89AB_CDEF, 8'hFF, 8'h01, 7, 8'h7F, 7'h00, 1'b1};
        vecs[2] = '{32'h89AB_CDEF, 8'hFF, 8'h01, 3, 8'hF7, 7'h46, 1'b1};
        vecs[3] = '{32'h0123_4567, 8'hFF, 8'h80, 7, 8'h7F, 7'h40, 1'b0};
        vecs[4] = '{32'h7654_3210, 8'hAA, 8'h00, 4, 8'hFF, 7'h7F, 1'b1};
        vecs[5] = '{32'h7654_3210, 8'hAA, 8'h00, 5, 8'hDF, 7'h12, 1'b1};
        vecs[6] = '{32'h0000_0009, 8'h01, 8'h01, 0, 8'hFE, 7'h10, 1'b0};

        // Reset then run blank: two frame ticks in 40 cycles.
        do_reset(3);
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (frame_tick) ticks++;
        end
        chk("blank_ticks", ticks, 2);

        foreach (vecs[v]) begin
            do_reset(2);
            cycle(1'b0, 1'b1, vecs[v].d, vecs[v].en, vecs[v].dp);
            run_to(FRAME - 1);
            idle(1);
            run_to(vecs[v].slot * RC + 1);
            idle(1);
            chk($sformatf("vec%0d", v), {15'd0, AN, CG, CF, CE, CD, CC, CB, CA, DP},
                {15'd0, vecs[v].an, vecs[v].seg, vecs[v].dpo});
        end

        // No tearing: a load at idx 3 does not alter idx 4..7 of the current frame.
        do_reset(2);
        cycle(1'b0, 1'b1, 32'h89AB_CDEF, 8'hFF, 8'h01);
        run_to(FRAME - 1);
        idle(1);
        run_to(3 * RC);
        cycle(1'b0, 1'b1, 32'h0, 8'hFF, 8'h00);
        run_to(4 * RC + 1);
        idle(1);
        chk("no_tear_old", {24'd0, AN}, {24'd0, 8'hEF});
        chk("no_tear_seg", {25'd0, CG, CF, CE, CD, CC, CB, CA}, {25'd0, 7'h03});
        run_to(0);
        idle(1 + GPH);
        chk("no_tear_new", {17'd0, AN, CG, CF, CE, CD, CC, CB, CA}, {17'd0, 8'hFE, 7'h40});

        // Bypass: load on the wrap edge is visible right after.
        run_to(FRAME - 1);
        cycle(1'b0, 1'b1, 32'h1, 8'hFF, 8'h00);
        idle(1 + GPH);
        chk("bypass", {17'd0, AN, CG, CF, CE, CD, CC, CB, CA}, {17'd0, 8'hFE, 7'h79});

        // Blanking pattern and reset in slot 5.
        do_reset(2);
        cycle(1'b0, 1'b1, 32'h7654_3210, 8'hAA, 8'h00);
        run_to(FRAME - 1);
        idle(1);
        run_to(5 * RC + 2);
        cycle(1'b1, 1'b0, digits, digit_en, dp_in);
        chk("reset_blank", {24'd0, AN}, {24'd0, 8'hFF});
        idle(1);
        chk("restart_tick", {23'd0, frame_tick, AN}, {23'd0, 1'b1, 8'hFF});

        // Randomized traffic against the reference.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
                  $urandom, 8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
